// File: rtl/fetch_r32i.sv
// fetch_r32i: RV32I instruction fetch unit. PC addresses are accepted over a valid/ready handshake,
// in-order memory reads land in a DEPTH-entry queue for decode. Optional macro: MISALIGN_TRAP_EN.
module fetch_r32i #(
    parameter int dataW = 32,
    parameter int addrW = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic [addrW-1:0] ProgAddr,
    input  logic             AddrValid,
    output logic             AddrReady,
    input  logic             Flush,
    output logic             MemReq,
    output logic [addrW-1:0] MemAddr,
    input  logic             MemGnt,
    input  logic             MemRValid,
    input  logic [dataW-1:0] MemRData,
    output logic             InstrValid,
    output logic [dataW-1:0] Instr,
    output logic [addrW-1:0] InstrAddr,
    input  logic             InstrReady,
    output logic             FetchFault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;

    logic [addrW-1:0] addr_q [DEPTH];
    logic [addrW-1:0] addr_d [DEPTH];
    logic [dataW-1:0] data_q [DEPTH];
    logic [dataW-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [DEPTH-1:0] fault_q, fault_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             used_q, used_d;
    cnt_t             drop_q, drop_d;

    logic credit, misaligned, open_slot, accept, pop, fill, drop_rsp;
    logic fill_found;
    ptr_t fill_ptr;
    cnt_t unfilled;
    sum_t pending;

    assign credit = (sum_t'(used_q) + sum_t'(drop_q)) < sum_t'(DEPTH);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (ProgAddr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned address never reaches memory; it is accepted without a grant.
    assign open_slot = nReset & AddrValid & credit & ~Flush;
    assign MemReq    = open_slot & ~misaligned;
    assign accept    = (MemReq & MemGnt) | (open_slot & misaligned);
    assign AddrReady = accept;
    assign MemAddr   = {ProgAddr[addrW-1:2], 2'b00};

    assign InstrValid = filled_q[rd_ptr_q];
    assign Instr      = data_q[rd_ptr_q];
    assign InstrAddr  = addr_q[rd_ptr_q];
    assign FetchFault = filled_q[rd_ptr_q] & fault_q[rd_ptr_q];

    assign pop      = InstrValid & InstrReady;
    assign drop_rsp = MemRValid & (drop_q != '0);
    assign fill     = MemRValid & (drop_q == '0) & fill_found;

    // Oldest allocated entry still waiting for data; fault entries are pre-filled and skipped.
    always_comb begin
        fill_found = 1'b0;
        fill_ptr   = '0;
        unfilled   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ptr_t idx;
            idx = rd_ptr_q + ptr_t'(i);
            if (cnt_t'(i) < used_q && !filled_q[idx]) begin
                unfilled = unfilled + cnt_t'(1);
                if (!fill_found) begin
                    fill_found = 1'b1;
                    fill_ptr   = idx;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        addr_d   = addr_q;
        data_d   = data_q;
        filled_d = filled_q;
        fault_d  = fault_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        drop_d   = drop_q;
        pending  = sum_t'(drop_q) + sum_t'(unfilled);

        if (Flush) begin
            filled_d = '0;
            fault_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
            if (MemRValid && pending != '0)
                pending = pending - sum_t'(1);
            drop_d = cnt_t'(pending);
        end else begin
            if (accept) begin
                addr_d[wr_ptr_q]   = ProgAddr;
                data_d[wr_ptr_q]   = '0;
                filled_d[wr_ptr_q] = misaligned;
                fault_d[wr_ptr_q]  = misaligned;
                wr_ptr_d           = wr_ptr_q + ptr_t'(1);
            end
            if (fill) begin
                data_d[fill_ptr]   = MemRData;
                filled_d[fill_ptr] = 1'b1;
            end
            if (drop_rsp)
                drop_d = drop_q - cnt_t'(1);
            if (pop) begin
                filled_d[rd_ptr_q] = 1'b0;
                fault_d[rd_ptr_q]  = 1'b0;
                rd_ptr_d           = rd_ptr_q + ptr_t'(1);
            end
            used_d = used_q + cnt_t'(accept) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            // NOTE: the entry storage is reset too, because Instr/InstrAddr must read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            filled_q <= '0;
            fault_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            drop_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            filled_q <= filled_d;
            fault_q  <= fault_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            drop_q   <= drop_d;
        end
    end

    rsp_has_owner: assert property (@(posedge clock) disable iff (!nReset)
        MemRValid |-> (drop_q != '0 || fill_found));

endmodule

// File: tb/tb_fetch_r32i.sv
// Directed bench for fetch_r32i: reset, streaming, backpressure, flush/drop and misaligned handling.
module tb_fetch_r32i;

    logic        clock = 1'b0;
    logic        nReset;
    logic [31:0] ProgAddr;
    logic        AddrValid;
    logic        AddrReady;
    logic        Flush;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemGnt;
    logic        MemRValid;
    logic [31:0] MemRData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrAddr;
    logic        InstrReady;
    logic        FetchFault;

    int n_checks = 0;
    int n_errors = 0;

    fetch_r32i #(.dataW(32), .addrW(32), .DEPTH(2)) dut (
        .clock      (clock),
        .nReset     (nReset),
        .ProgAddr   (ProgAddr),
        .AddrValid  (AddrValid),
        .AddrReady  (AddrReady),
        .Flush      (Flush),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemGnt     (MemGnt),
        .MemRValid  (MemRValid),
        .MemRData   (MemRData),
        .InstrValid (InstrValid),
        .Instr      (Instr),
        .InstrAddr  (InstrAddr),
        .InstrReady (InstrReady),
        .FetchFault (FetchFault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 + a;
    endfunction

    logic [31:0] addrs [3];

    initial begin
        int          ai, oi, g_cyc, v_cyc;
        logic        pend, got;
        logic [31:0] pend_a, pa;

        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        nReset = 1'b0; ProgAddr = '0; AddrValid = 1'b0; Flush = 1'b0; MemGnt = 1'b0;
        MemRValid = 1'b0; MemRData = '0; InstrReady = 1'b0;
        tick(); tick();
        #1;
        check("rst_valid", InstrValid, 1'b0);
        check("rst_memreq", MemReq, 1'b0);
        check("rst_ready", AddrReady, 1'b0);
        check("rst_instr", Instr, 32'h0);
        check("rst_iaddr", InstrAddr, 32'h0);
        check("rst_fault", FetchFault, 1'b0);
        nReset = 1'b1;
        tick();

        // Reset mid-fetch with one entry filled and one in flight.
        AddrValid = 1'b1; ProgAddr = 32'h40; MemGnt = 1'b1;
        #1 check("r_acc0", AddrReady, 1'b1);
        tick();
        ProgAddr = 32'h44; MemRValid = 1'b1; MemRData = dat(32'h40);
        tick();
        MemRValid = 1'b0; ProgAddr = 32'h48;
        #1 check("r_filled", InstrValid, 1'b1);
        check("r_filled_addr", InstrAddr, 32'h40);
        #1 nReset = 1'b0;
        #1 check("r_async_valid", InstrValid, 1'b0);
        check("r_async_memreq", MemReq, 1'b0);
        check("r_async_iaddr", InstrAddr, 32'h0);
        tick();
        nReset = 1'b1; ProgAddr = 32'h80; InstrReady = 1'b1;
        #1 check("r_post_acc", AddrReady, 1'b1);
        tick();
        AddrValid = 1'b0; MemRValid = 1'b1; MemRData = dat(32'h80);
        #1 check("r_post_wait", InstrValid, 1'b0);
        tick();
        MemRValid = 1'b0;
        #1 check("r_post_valid", InstrValid, 1'b1);
        check("r_post_iaddr", InstrAddr, 32'h80);
        check("r_post_instr", Instr, dat(32'h80));
        tick();
        #1 check("r_post_empty", InstrValid, 1'b0);

        // Stream of three addresses, memory answering one cycle after each grant.
        ai = 0; oi = 0; g_cyc = -1; v_cyc = -1; pend = 1'b0; pend_a = '0;
        MemGnt = 1'b1; InstrReady = 1'b1;
        for (int cyc = 0; cyc < 30 && oi < 3; cyc++) begin
            AddrValid = (ai < 3);
            if (ai < 3) ProgAddr = addrs[ai];
            MemRValid = pend;
            MemRData  = dat(pend_a);
            #1;
            if (InstrValid) begin
                check("stream_addr", InstrAddr, addrs[oi]);
                check("stream_data", Instr, dat(addrs[oi]));
                if (oi == 0) v_cyc = cyc;
                oi++;
            end
            got = AddrReady;
            pa  = ProgAddr;
            if (got && g_cyc < 0) g_cyc = cyc;
            tick();
            pend = got; pend_a = pa;
            if (got) ai++;
        end
        check("stream_count", oi, 3);
        check("stream_latency", v_cyc - g_cyc, 2);
        AddrValid = 1'b0; MemRValid = 1'b0;
        tick();

        // Backpressure: two accepts fill the queue, the head stays put.
        InstrReady = 1'b0; AddrValid = 1'b1; ProgAddr = 32'h0;
        #1 check("bp_acc0", AddrReady, 1'b1);
        tick();
        ProgAddr = 32'h4; MemRValid = 1'b1; MemRData = dat(32'h0);
        #1 check("bp_acc1", AddrReady, 1'b1);
        tick();
        ProgAddr = 32'h8; MemRData = dat(32'h4);
        #1 check("bp_full_memreq", MemReq, 1'b0);
        check("bp_full_ready", AddrReady, 1'b0);
        check("bp_head_instr", Instr, dat(32'h0));
        check("bp_head_addr", InstrAddr, 32'h0);
        tick();
        MemRValid = 1'b0;
        #1 check("bp_hold_instr", Instr, dat(32'h0));
        check("bp_hold_ready", AddrReady, 1'b0);
        tick();
        InstrReady = 1'b1;
        #1 check("bp_release_ready", AddrReady, 1'b0);
        tick();
        #1 check("bp_resume_ready", AddrReady, 1'b1);
        check("bp_next_instr", Instr, dat(32'h4));
        check("bp_next_addr", InstrAddr, 32'h4);
        tick();
        AddrValid = 1'b0; MemRValid = 1'b1; MemRData = dat(32'h8);
        #1 check("bp_gap", InstrValid, 1'b0);
        tick();
        MemRValid = 1'b0;
        #1 check("bp_last_addr", InstrAddr, 32'h8);
        check("bp_last_instr", Instr, dat(32'h8));
        tick();
        #1 check("bp_empty", InstrValid, 1'b0);

        // Flush with two grants outstanding; both late responses are discarded.
        AddrValid = 1'b1; ProgAddr = 32'h200;
        tick();
        ProgAddr = 32'h204;
        tick();
        AddrValid = 1'b0; Flush = 1'b1;
        #1 check("fl_memreq", MemReq, 1'b0);
        tick();
        Flush = 1'b0; MemRValid = 1'b1; MemRData = 32'hDEAD; AddrValid = 1'b1; ProgAddr = 32'h100;
        #1 check("fl_valid", InstrValid, 1'b0);
        check("fl_no_credit", AddrReady, 1'b0);
        tick();
        MemRData = 32'hBEEF;
        #1 check("fl_credit_back", AddrReady, 1'b1);
        check("fl_drop_dead", InstrValid, 1'b0);
        tick();
        AddrValid = 1'b0; MemRData = dat(32'h100);
        #1 check("fl_drop_beef", InstrValid, 1'b0);
        tick();
        MemRValid = 1'b0;
        #1 check("fl_new_valid", InstrValid, 1'b1);
        check("fl_new_instr", Instr, dat(32'h100));
        check("fl_new_addr", InstrAddr, 32'h100);
        tick();
        #1 check("fl_empty", InstrValid, 1'b0);

        // Flush coinciding with a response: only one further response is dropped.
        AddrValid = 1'b1; ProgAddr = 32'h300;
        tick();
        ProgAddr = 32'h304;
        tick();
        AddrValid = 1'b0; Flush = 1'b1; MemRValid = 1'b1; MemRData = 32'h1111;
        tick();
        Flush = 1'b0; MemRData = 32'h2222; AddrValid = 1'b1; ProgAddr = 32'h400;
        #1 check("fr_accept", AddrReady, 1'b1);
        tick();
        AddrValid = 1'b0; MemRData = dat(32'h400);
        #1 check("fr_dropped", InstrValid, 1'b0);
        tick();
        MemRValid = 1'b0;
        #1 check("fr_valid", InstrValid, 1'b1);
        check("fr_instr", Instr, dat(32'h400));
        check("fr_addr", InstrAddr, 32'h400);
        tick();
        #1 check("fr_empty", InstrValid, 1'b0);

        // Misaligned program address.
        MemGnt = 1'b0; AddrValid = 1'b1; ProgAddr = 32'h6;
`ifdef MISALIGN_TRAP_EN
        #1 check("ma_memreq", MemReq, 1'b0);
        check("ma_ready", AddrReady, 1'b1);
        tick();
        AddrValid = 1'b0;
        #1 check("ma_valid", InstrValid, 1'b1);
        check("ma_fault", FetchFault, 1'b1);
        check("ma_instr", Instr, 32'h0);
        check("ma_addr", InstrAddr, 32'h6);
        tick();
`else
        #1 check("ma_memreq", MemReq, 1'b1);
        check("ma_memaddr", MemAddr, 32'h4);
        check("ma_nogrant", AddrReady, 1'b0);
        tick();
        MemGnt = 1'b1;
        #1 check("ma_grant", AddrReady, 1'b1);
        tick();
        AddrValid = 1'b0; MemRValid = 1'b1; MemRData = dat(32'h4);
        tick();
        MemRValid = 1'b0;
        #1 check("ma_valid", InstrValid, 1'b1);
        check("ma_fault", FetchFault, 1'b0);
        check("ma_instr", Instr, dat(32'h4));
        check("ma_addr", InstrAddr, 32'h6);
        tick();
`endif
        #1 check("ma_empty", InstrValid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
